// File: rtl/cpu_sequencer_if.sv
// Bus bundle between program RAM / data-path decoder and the EE1 control sequencer.
// master drives RAM data and control requests; slave is the sequencer itself.
interface cpu_sequencer_if #(
  parameter int IW    = 16,
  parameter int CNT_W = 16
);
  logic [IW-1:0]    MemData;
  logic             Resume;
  logic             MulReady;
  logic             FETCH;
  logic             EXEC1;
  logic             EXEC2;
  logic             EXEC3;
  logic [IW-1:0]    IR_postmux;
  logic [IW-1:0]    IR;
  logic             Halted;
  logic             Retire;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    output MemData, Resume, MulReady,
    input  FETCH, EXEC1, EXEC2, EXEC3, IR_postmux, IR, Halted, Retire, InstrCount
  );

  modport slave (
    input  MemData, Resume, MulReady,
    output FETCH, EXEC1, EXEC2, EXEC3, IR_postmux, IR, Halted, Retire, InstrCount
  );
endinterface

// File: rtl/cpu_sequencer.sv
// EE1 CPU control sequencer: one-hot FETCH/EXEC timing, IR, STP halt and retire counter.
// Optional macro MUL_WAIT_EN stalls MUL (EXEC2) and MULR (EXEC1) until MulReady.
module cpu_sequencer #(
  parameter int IW    = 16,
  parameter int CNT_W = 16
) (
  input  logic           CLOCK,
  input  logic           RESET,
  cpu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EX1   = 3'd1,
    S_EX2   = 3'd2,
    S_EX3   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic [IW-1:0]    ir_postmux;
  logic [3:0]       opc;
  logic [3:0]       sub;
  logic [3:0]       ir_opc;

  // RAM data is only valid in EXEC1; decode it directly then, the latched IR otherwise.
  assign ir_postmux = (state_q == S_EX1) ? bus.MemData : ir_q;
  assign opc        = ir_postmux[IW-1 -: 4];
  assign sub        = ir_postmux[IW-5 -: 4];
  assign ir_opc     = ir_q[IW-1 -: 4];

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_EX1;
      S_EX1: begin
        case (opc)
          4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
          4'b1110, 4'b1111, 4'b1001: state_d = S_EX2;
          4'b1010: begin
            if (sub == 4'b1000)      state_d = S_EX2;
            else if (sub == 4'b0000) state_d = S_HALT;
            else                     state_d = S_FETCH;
`ifdef MUL_WAIT_EN
            if ((sub == 4'b0110) && !bus.MulReady) state_d = S_EX1;
`endif
          end
          default: state_d = S_FETCH;
        endcase
        retire = (state_d != S_EX2) && (state_d != S_EX1);
      end
      S_EX2: begin
        state_d = (ir_opc == 4'b1001) ? S_EX3 : S_FETCH;
`ifdef MUL_WAIT_EN
        if ((ir_opc == 4'b0100) && !bus.MulReady) state_d = S_EX2;
`endif
        retire = (state_d == S_FETCH);
      end
      S_EX3: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: begin
        if (bus.Resume) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ir_d  = (state_q == S_EX1) ? bus.MemData : ir_q;
  // Counter saturates rather than wrapping so a long run never reports a small count.
  assign cnt_d = (retire && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.FETCH      = (state_q == S_FETCH);
  assign bus.EXEC1      = (state_q == S_EX1);
  assign bus.EXEC2      = (state_q == S_EX2);
  assign bus.EXEC3      = (state_q == S_EX3);
  assign bus.Halted     = (state_q == S_HALT);
  assign bus.IR_postmux = ir_postmux;
  assign bus.IR         = ir_q;
  assign bus.Retire     = retire;
  assign bus.InstrCount = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: main instance plus a 2-bit-counter instance for saturation.
module tb_cpu_sequencer;
  logic CLOCK;
  logic RESET;
  int   checks;
  int   failures;

  cpu_sequencer_if #(.IW(16), .CNT_W(16)) bus ();
  cpu_sequencer_if #(.IW(16), .CNT_W(2))  sat_bus ();

  cpu_sequencer #(.IW(16), .CNT_W(16)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  cpu_sequencer #(.IW(16), .CNT_W(2)) dut_sat (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (sat_bus)
  );

  assign sat_bus.MemData  = bus.MemData;
  assign sat_bus.Resume   = bus.Resume;
  assign sat_bus.MulReady = bus.MulReady;

  wire [3:0] flags = {bus.FETCH, bus.EXEC1, bus.EXEC2, bus.EXEC3};

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    bus.MemData = 16'h0000; bus.Resume = 1'b0; bus.MulReady = 1'b0;
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", flags, 4'b1000); end
    checks++; if (bus.Halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.Halted); end
    checks++; if (bus.Retire !== 1'b0) begin failures++; $display("FAIL reset_retire got=%b exp=0", bus.Retire); end
    checks++; if (bus.IR !== 16'h0000) begin failures++; $display("FAIL reset_ir got=%h exp=0000", bus.IR); end
    checks++; if (bus.IR_postmux !== 16'h0000) begin failures++; $display("FAIL reset_postmux got=%h exp=0000", bus.IR_postmux); end
    checks++; if (bus.InstrCount !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.InstrCount); end
    $display("txn reset done");
  endtask

  task automatic test_lda();
    bus.MemData = 16'h0005;
    step();
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL lda_ex1_flags got=%b exp=%b", flags, 4'b0100); end
    checks++; if (bus.IR_postmux !== 16'h0005) begin failures++; $display("FAIL lda_postmux got=%h exp=0005", bus.IR_postmux); end
    checks++; if (bus.Retire !== 1'b0) begin failures++; $display("FAIL lda_ex1_retire got=%b exp=0", bus.Retire); end
    step();
    bus.MemData = 16'hFFFF;
    #1;
    checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL lda_ex2_flags got=%b exp=%b", flags, 4'b0010); end
    checks++; if (bus.IR !== 16'h0005) begin failures++; $display("FAIL lda_ir got=%h exp=0005", bus.IR); end
    checks++; if (bus.IR_postmux !== 16'h0005) begin failures++; $display("FAIL lda_ex2_postmux got=%h exp=0005", bus.IR_postmux); end
    checks++; if (bus.Retire !== 1'b1) begin failures++; $display("FAIL lda_ex2_retire got=%b exp=1", bus.Retire); end
    step();
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL lda_end_flags got=%b exp=%b", flags, 4'b1000); end
    checks++; if (bus.InstrCount !== 16'd1) begin failures++; $display("FAIL lda_count got=%0d exp=1", bus.InstrCount); end
    $display("txn LDA 0005 count=%0d", bus.InstrCount);
  endtask

  task automatic test_ldn();
    bus.MemData = 16'h9003;
    step();
    checks++; if (flags !== 4'b0100 || bus.Retire !== 1'b0) begin failures++; $display("FAIL ldn_ex1 got=%b/%b exp=0100/0", flags, bus.Retire); end
    step();
    checks++; if (flags !== 4'b0010 || bus.Retire !== 1'b0) begin failures++; $display("FAIL ldn_ex2 got=%b/%b exp=0010/0", flags, bus.Retire); end
    step();
    checks++; if (flags !== 4'b0001 || bus.Retire !== 1'b1) begin failures++; $display("FAIL ldn_ex3 got=%b/%b exp=0001/1", flags, bus.Retire); end
    step();
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL ldn_end_flags got=%b exp=1000", flags); end
    checks++; if (bus.InstrCount !== 16'd2) begin failures++; $display("FAIL ldn_count got=%0d exp=2", bus.InstrCount); end
    checks++; if (sat_bus.InstrCount !== 2'd2) begin failures++; $display("FAIL sat_count_2 got=%0d exp=2", sat_bus.InstrCount); end
    $display("txn LDN 9003 count=%0d", bus.InstrCount);
  endtask

  task automatic test_single_exec();
    logic [15:0] ops [2];
    ops[0] = 16'h5010;
    ops[1] = 16'h8123;
    for (int i = 0; i < 2; i++) begin
      bus.MemData = ops[i];
      step();
      checks++; if (flags !== 4'b0100 || bus.Retire !== 1'b1) begin failures++; $display("FAIL single_ex1_%0d got=%b/%b exp=0100/1", i, flags, bus.Retire); end
      checks++; if (bus.IR_postmux !== ops[i]) begin failures++; $display("FAIL single_postmux_%0d got=%h exp=%h", i, bus.IR_postmux, ops[i]); end
      step();
      checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL single_end_%0d got=%b exp=1000", i, flags); end
      $display("txn single %h count=%0d", ops[i], bus.InstrCount);
    end
    checks++; if (bus.InstrCount !== 16'd4) begin failures++; $display("FAIL single_count got=%0d exp=4", bus.InstrCount); end
    checks++; if (bus.IR !== 16'h8123) begin failures++; $display("FAIL single_ir got=%h exp=8123", bus.IR); end
  endtask

  task automatic test_stp();
    bus.MemData = 16'hA000;
    step();
    checks++; if (flags !== 4'b0100 || bus.Retire !== 1'b1) begin failures++; $display("FAIL stp_ex1 got=%b/%b exp=0100/1", flags, bus.Retire); end
    step();
    for (int i = 0; i < 10; i++) begin
      checks++; if (flags !== 4'b0000 || bus.Halted !== 1'b1 || bus.Retire !== 1'b0) begin failures++; $display("FAIL stp_halt_%0d got=%b/%b/%b exp=0000/1/0", i, flags, bus.Halted, bus.Retire); end
      step();
    end
    bus.Resume = 1'b1;
    step();
    bus.Resume = 1'b0;
    checks++; if (flags !== 4'b1000 || bus.Halted !== 1'b0) begin failures++; $display("FAIL stp_resume got=%b/%b exp=1000/0", flags, bus.Halted); end
    checks++; if (bus.InstrCount !== 16'd5) begin failures++; $display("FAIL stp_count got=%0d exp=5", bus.InstrCount); end
    checks++; if (sat_bus.InstrCount !== 2'd3) begin failures++; $display("FAIL sat_count_5 got=%0d exp=3", sat_bus.InstrCount); end
    $display("txn STP A000 count=%0d", bus.InstrCount);
  endtask

  task automatic test_sss();
    bus.MemData = 16'hA800;
    step();
    checks++; if (flags !== 4'b0100 || bus.Retire !== 1'b0) begin failures++; $display("FAIL pop_ex1 got=%b/%b exp=0100/0", flags, bus.Retire); end
    step();
    checks++; if (flags !== 4'b0010 || bus.Retire !== 1'b1) begin failures++; $display("FAIL pop_ex2 got=%b/%b exp=0010/1", flags, bus.Retire); end
    step();
    bus.MemData = 16'hA300;
    step();
    checks++; if (flags !== 4'b0100 || bus.Retire !== 1'b1) begin failures++; $display("FAIL sss_other got=%b/%b exp=0100/1", flags, bus.Retire); end
    step();
    checks++; if (flags !== 4'b1000 || bus.InstrCount !== 16'd7) begin failures++; $display("FAIL sss_end got=%b/%0d exp=1000/7", flags, bus.InstrCount); end
    $display("txn SSS A800,A300 count=%0d", bus.InstrCount);
  endtask

  task automatic test_reset_mid_exec();
    bus.MemData = 16'h9007;
    step();
    step();
    checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL midrst_ex2 got=%b exp=0010", flags); end
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL midrst_flags got=%b exp=1000", flags); end
    checks++; if (bus.IR !== 16'h0000) begin failures++; $display("FAIL midrst_ir got=%h exp=0000", bus.IR); end
    checks++; if (bus.InstrCount !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", bus.InstrCount); end
    bus.MemData = 16'h5000;
    step();
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL midrst_resume got=%b exp=0100", flags); end
    step();
    $display("txn reset during LDN 9007 count=%0d", bus.InstrCount);
  endtask

  task automatic test_mul_wait();
    bus.MemData  = 16'h4002;
    bus.MulReady = 1'b0;
    step();
    checks++; if (flags !== 4'b0100 || bus.Retire !== 1'b0) begin failures++; $display("FAIL mul_ex1 got=%b/%b exp=0100/0", flags, bus.Retire); end
    step();
`ifdef MUL_WAIT_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (flags !== 4'b0010 || bus.Retire !== 1'b0) begin failures++; $display("FAIL mul_stall_%0d got=%b/%b exp=0010/0", i, flags, bus.Retire); end
      step();
    end
    bus.MulReady = 1'b1;
    #1;
`endif
    checks++; if (flags !== 4'b0010 || bus.Retire !== 1'b1) begin failures++; $display("FAIL mul_ex2_exit got=%b/%b exp=0010/1", flags, bus.Retire); end
    step();
    checks++; if (flags !== 4'b1000 || bus.InstrCount !== 16'd2) begin failures++; $display("FAIL mul_end got=%b/%0d exp=1000/2", flags, bus.InstrCount); end
    bus.MulReady = 1'b0;
    bus.MemData  = 16'hA600;
    step();
`ifdef MUL_WAIT_EN
    checks++; if (flags !== 4'b0100 || bus.Retire !== 1'b0) begin failures++; $display("FAIL mulr_stall got=%b/%b exp=0100/0", flags, bus.Retire); end
    step();
    checks++; if (flags !== 4'b0100 || bus.IR !== 16'hA600) begin failures++; $display("FAIL mulr_hold got=%b/%h exp=0100/a600", flags, bus.IR); end
    bus.MulReady = 1'b1;
    #1;
`endif
    checks++; if (flags !== 4'b0100 || bus.Retire !== 1'b1) begin failures++; $display("FAIL mulr_exit got=%b/%b exp=0100/1", flags, bus.Retire); end
    step();
    bus.MulReady = 1'b0;
    checks++; if (flags !== 4'b1000 || bus.InstrCount !== 16'd3) begin failures++; $display("FAIL mulr_end got=%b/%0d exp=1000/3", flags, bus.InstrCount); end
    $display("txn MUL 4002, MULR A600 count=%0d", bus.InstrCount);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b1;
    test_reset();
    test_lda();
    test_ldn();
    test_single_exec();
    test_stp();
    test_sss();
    test_reset_mid_exec();
    test_mul_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
